// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (I) and load/store (D), D first with fetch anti-starvation.
// Optional MEM_TIMEOUT_EN aborts a BUSY transaction after TIMEOUT_CYCLES cycles without m_ack.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_err,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  d_err,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_ack,
  input  logic [DATA_W-1:0]     m_rdata
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;
  state_t state;
  logic [CW-1:0] starve_cnt;
  logic idle, busy, fetch_wins, tmo, done;
  assign idle       = state == IDLE;
  assign busy       = state == BUSY_I || state == BUSY_D;
  assign fetch_wins = if_req && (!d_req || starve_cnt >= LIM);
  assign if_gnt     = idle && fetch_wins;
  assign d_gnt      = idle && d_req && !fetch_wins;
  assign done       = busy && (m_ack || tmo);
`ifdef MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
  // an ack in the expiry cycle wins over the timeout
  assign tmo = busy && !m_ack && tmo_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) tmo_cnt <= '0;
    else tmo_cnt <= busy && !m_ack ? tmo_cnt + 1'b1 : '0;
`else
  assign tmo = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_wstrb    <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_rvalid  <= 1'b0;
      d_rvalid   <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
      if_err     <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      starve_cnt <= if_req && !if_gnt ? (starve_cnt == LIM ? LIM : starve_cnt + 1'b1) : '0;
      if_rvalid  <= state == RESP_I;
      d_rvalid   <= state == RESP_D;
      case (state)
        IDLE: if (if_gnt || d_gnt) begin
          state   <= if_gnt ? BUSY_I : BUSY_D;
          m_req   <= 1'b1;
          m_we    <= d_gnt && d_we;
          m_wstrb <= d_gnt ? d_wstrb : '0;
          m_addr  <= if_gnt ? if_addr : d_addr;
          m_wdata <= if_gnt ? '0 : d_wdata;
        end
        BUSY_I, BUSY_D: if (done) begin
          state <= state == BUSY_I ? RESP_I : RESP_D;
          m_req <= 1'b0;
          if (state == BUSY_I) begin
            if_rdata <= m_ack && !m_we ? m_rdata : '0;
            if_err   <= tmo;
          end else begin
            d_rdata <= m_ack && !m_we ? m_rdata : '0;
            d_err   <= tmo;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, corner sequences and a random run against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int LIM = 4;
  localparam int TMO = 8;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr = 0, if_rdata;
  logic d_req = 0, d_we = 0, d_gnt, d_rvalid, d_err;
  logic [3:0] d_wstrb = 0;
  logic [31:0] d_addr = 0, d_wdata = 0, d_rdata;
  logic m_req, m_we, m_ack = 0;
  logic [3:0] m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  typedef struct packed { logic ir; logic dr; logic gi; logic gd; } arb_t;
  typedef struct packed {
    logic side; logic we; logic [3:0] strb;
    logic [31:0] addr; logic [31:0] wdata; logic [31:0] mrdata; logic [31:0] exp;
    int lat;
  } txn_t;
  int c, sc, gnt_cyc, lat_t, rv_cyc, free_at;
  bit pend, p_side, p_we, rv_side, l_gi, l_gd, i_contended;
  logic [3:0] p_strb;
  logic [31:0] p_addr, p_wdata, rv_data;
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 0;
    if_req = 0; d_req = 0; m_ack = 0; d_we = 0; d_wstrb = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    c = 0; sc = 0; pend = 0; free_at = 0; rv_cyc = -100; l_gi = 0; l_gd = 0;
  endtask
  task automatic run_txn(input txn_t t);
    int e;
    e = t.lat != 0 ? t.lat : TMO;
    for (int k = 0; k <= e + 3; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 && t.side) begin
        d_req = 1; d_we = t.we; d_wstrb = t.strb; d_addr = t.addr; d_wdata = t.wdata;
      end else if (k == 0) begin
        if_req = 1; if_addr = t.addr;
      end else begin
        if_req = 0; d_req = 0;
      end
      m_ack = t.lat != 0 && k == t.lat;
      m_rdata = m_ack ? t.mrdata : $urandom;
      @(negedge clk);
      if (k == 0) begin
        chk("tbl_if_gnt", if_gnt, !t.side);
        chk("tbl_d_gnt", d_gnt, t.side);
      end
      if (k >= 1 && k <= e) begin
        chk("tbl_m_req_hi", m_req, 1);
        chk("tbl_m_addr", m_addr, t.addr);
        chk("tbl_m_we", m_we, t.side && t.we);
        chk("tbl_m_wstrb", m_wstrb, t.side ? t.strb : 4'h0);
        if (t.side) chk("tbl_m_wdata", m_wdata, t.wdata);
      end
      if (k == e + 1) chk("tbl_m_req_lo", m_req, 0);
      chk("tbl_rvalid_own", t.side ? d_rvalid : if_rvalid, k == e + 2);
      chk("tbl_rvalid_other", t.side ? if_rvalid : d_rvalid, 0);
      if (k == e + 2) begin
        chk("tbl_rdata", t.side ? d_rdata : if_rdata, t.exp);
        chk("tbl_err", t.side ? d_err : if_err, t.lat == 0);
      end
    end
    m_ack = 0;
  endtask
  task automatic step(input bit starve_mode);
    bit idle, fw, egi, egd, emr;
    @(posedge clk);
    #1;
    c++;
    if (!if_req || l_gi) begin
      if_req = starve_mode || $urandom_range(0, 2) == 0;
      if_addr = $urandom;
    end else if (!starve_mode && $urandom_range(0, 15) == 0) if_req = 0;
    if (!d_req || l_gd) begin
      d_req = starve_mode || $urandom_range(0, 2) == 0;
      d_we = $urandom_range(0, 1); d_wstrb = $urandom; d_addr = $urandom; d_wdata = $urandom;
    end else if (!starve_mode && $urandom_range(0, 15) == 0) d_req = 0;
    m_ack = pend ? c - gnt_cyc >= lat_t : !starve_mode && $urandom_range(0, 7) == 0;
    m_rdata = $urandom;
    @(negedge clk);
    idle = !pend && c >= free_at;
    fw = if_req && (!d_req || sc >= LIM);
    egi = idle && fw;
    egd = idle && d_req && !fw;
    chk("if_gnt", if_gnt, egi);
    chk("d_gnt", d_gnt, egd);
    emr = pend && c > gnt_cyc;
    chk("m_req", m_req, emr);
    if (emr) begin
      chk("m_addr", m_addr, p_addr);
      chk("m_we", m_we, p_we);
      chk("m_wstrb", m_wstrb, p_strb);
      if (p_side) chk("m_wdata", m_wdata, p_wdata);
    end
    chk("if_rvalid", if_rvalid, c == rv_cyc && !rv_side);
    chk("d_rvalid", d_rvalid, c == rv_cyc && rv_side);
    if (c == rv_cyc) begin
      chk("rdata", rv_side ? d_rdata : if_rdata, rv_data);
      chk("err", rv_side ? d_err : if_err, 0);
    end
    if (egi && d_req) i_contended = 1;
    sc = if_req && !egi ? (sc < LIM ? sc + 1 : LIM) : 0;
    if (egi || egd) begin
      pend = 1; gnt_cyc = c; p_side = egd;
      p_addr = egi ? if_addr : d_addr;
      p_we = egd && d_we;
      p_strb = egd ? d_wstrb : 4'h0;
      p_wdata = d_wdata;
      lat_t = $urandom_range(1, 4);
    end else if (emr && m_ack) begin
      pend = 0; rv_cyc = c + 2; rv_side = p_side; rv_data = p_we ? 32'h0 : m_rdata; free_at = c + 2;
    end
    l_gi = egi; l_gd = egd;
  endtask
  arb_t arb[4];
  txn_t vec[$];
  txn_t t;
  initial begin
    arb = '{'{1'b0, 1'b0, 1'b0, 1'b0}, '{1'b1, 1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b0, 1'b1}};
    t = '{1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h13, 32'h13, 3}; vec.push_back(t);
    t = '{1'b1, 1'b1, 4'b0011, 32'h100, 32'hAABBCCDD, 32'h55AA55AA, 32'h0, 2}; vec.push_back(t);
    t = '{1'b1, 1'b0, 4'hF, 32'h204, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1}; vec.push_back(t);
    t = '{1'b0, 1'b0, 4'h0, 32'h14, 32'h0, 32'h12345678, 32'h12345678, 1}; vec.push_back(t);
    t = '{1'b1, 1'b0, 4'h0, 32'h300, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, TMO}; vec.push_back(t);
`ifdef MEM_TIMEOUT_EN
    t = '{1'b1, 1'b0, 4'h0, 32'h400, 32'h0, 32'h0, 32'h0, 0}; vec.push_back(t);
`endif
    #12;
    chk("rst_ctrl", {m_req, m_we, m_wstrb, if_rvalid, d_rvalid, if_err, d_err}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_m_wdata", m_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    foreach (arb[i]) begin
      if_req = arb[i].ir; d_req = arb[i].dr;
      #1;
      chk("arb_if_gnt", if_gnt, arb[i].gi);
      chk("arb_d_gnt", d_gnt, arb[i].gd);
    end
    do_reset();
    foreach (vec[i]) run_txn(vec[i]);
    chk("if_rdata_hold", if_rdata, 32'h12345678);
    do_reset();
    @(posedge clk); #1 d_req = 1; d_we = 0; d_addr = 32'h500;
    @(negedge clk); chk("rst_seq_gnt", d_gnt, 1);
    @(posedge clk); #1 d_req = 0;
    @(negedge clk); chk("rst_seq_mreq", m_req, 1);
    @(posedge clk); #2 rst_n = 0;
    #1 chk("rst_async_mreq", m_req, 0);
    #3 rst_n = 1;
    @(posedge clk); #1 m_ack = 1; m_rdata = 32'h77;
    @(posedge clk); #1 m_ack = 0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_seq_no_rvalid", {d_rvalid, if_rvalid}, 0);
      chk("rst_seq_mreq_lo", m_req, 0);
    end
    @(posedge clk); #1 d_req = 1;
    @(negedge clk); chk("rst_seq_idle", d_gnt, 1);
    do_reset();
    @(posedge clk); #1 m_ack = 1;
    @(negedge clk); chk("stray_mreq", m_req, 0);
    @(posedge clk); #1 m_ack = 0;
    repeat (3) begin
      @(negedge clk);
      chk("stray_no_rvalid", {d_rvalid, if_rvalid}, 0);
    end
    @(posedge clk); #1 if_req = 1;
    @(negedge clk); chk("stray_idle", if_gnt, 1);
    do_reset();
    i_contended = 0;
    repeat (60) step(1);
    chk("starve_i_wins", i_contended, 1);
    do_reset();
    repeat (3000) step(0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
